// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: FETCH -> EXEC -> (MEM) -> WB, or EXEC -> TRAP.
// Define MCSEQ_TIMEOUT_EN to add a memory-wait watchdog that raises an access fault.
module multicycle_seq #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_is_load,
  input  logic       i_is_store,
  input  logic       i_regfile_we,
  input  logic       i_csr_we,
  input  logic       i_trap_req,
  input  logic       i_imem_ready,
  input  logic       i_dmem_ready,
  output logic       o_imem_req,
  output logic       o_ir_we,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_regfile_we,
  output logic       o_csr_we,
  output logic       o_pc_we,
  output logic       o_trap_commit,
  output logic       o_instret,
  output logic       o_t_access_fault,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_TRAP  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MCSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             waiting;

  // Counter saturates at the limit; the fault cycle itself moves on to TRAP.
  always_comb begin
    waiting    = ((state_q == S_FETCH) && !i_imem_ready) ||
                 ((state_q == S_MEM)   && !i_dmem_ready);
    timeout    = ((state_q == S_FETCH) || (state_q == S_MEM)) &&
                 (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    wait_cnt_d = (waiting && !timeout) ? wait_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    o_imem_req       = 1'b0;
    o_ir_we          = 1'b0;
    o_dmem_req       = 1'b0;
    o_dmem_we        = 1'b0;
    o_regfile_we     = 1'b0;
    o_csr_we         = 1'b0;
    o_pc_we          = 1'b0;
    o_trap_commit    = 1'b0;
    o_instret        = 1'b0;
    o_t_access_fault = 1'b0;
    o_state          = 3'd0;

    case (state_q)
      S_FETCH: begin
        o_state = 3'd0;
        if (timeout) begin
          o_t_access_fault = 1'b1;
          state_d          = S_TRAP;
        end else begin
          o_imem_req = 1'b1;
          if (i_imem_ready) begin
            o_ir_we = 1'b1;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        o_state = 3'd1;
        // A trap wins over a pending load/store so no memory side effect occurs.
        if (i_trap_req)                   state_d = S_TRAP;
        else if (i_is_load || i_is_store) state_d = S_MEM;
        else                              state_d = S_WB;
      end
      S_MEM: begin
        o_state = 3'd2;
        if (timeout) begin
          o_t_access_fault = 1'b1;
          state_d          = S_TRAP;
        end else begin
          o_dmem_req = 1'b1;
          o_dmem_we  = i_is_store;
          if (i_dmem_ready) state_d = S_WB;
        end
      end
      S_WB: begin
        o_state      = 3'd3;
        o_regfile_we = i_regfile_we;
        o_csr_we     = i_csr_we;
        o_pc_we      = 1'b1;
        o_instret    = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        o_state       = 3'd4;
        o_trap_commit = 1'b1;
        o_pc_we       = 1'b1;
        state_d       = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset silences every output immediately, including a half-done store.
    if (i_rst) begin
      o_imem_req       = 1'b0;
      o_ir_we          = 1'b0;
      o_dmem_req       = 1'b0;
      o_dmem_we        = 1'b0;
      o_regfile_we     = 1'b0;
      o_csr_we         = 1'b0;
      o_pc_we          = 1'b0;
      o_trap_commit    = 1'b0;
      o_instret        = 1'b0;
      o_t_access_fault = 1'b0;
      o_state          = 3'd0;
    end
  end

endmodule
